// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, drives a 1-cycle synchronous imem,
// tags returning words with their PC and buffers them for decode.
module fetch_sequencer #(
    parameter int PC_W      = 12,
    parameter int INSTR_W   = 32,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [PC_W-1:0]    inst_pc,
    output logic               fetch_err
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;

    logic                vld_p1;
    logic                kill_p1;
    logic [PC_W-1:0]     pc_p1;

    logic [INSTR_W-1:0]  buf_data [BUF_DEPTH];
    logic [PC_W-1:0]     buf_pc   [BUF_DEPTH];
    logic [AW-1:0]       rd_ptr_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [CW-1:0]       count_q;
    logic                fetch_err_q;

    logic                pop;
    logic                push;
    logic                credit;
    logic                issue;
    logic [CW-1:0]       occupancy;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

    // Slots already committed (buffered + returning) minus the one leaving this cycle.
    always_comb begin
        pop       = (count_q != '0) && inst_ready;
        occupancy = count_q + CW'(vld_p1) - CW'(pop);
        credit    = occupancy < CW'(BUF_DEPTH);
        issue     = !reset && fetch_en && !redirect_valid && credit;
        push      = vld_p1 && !kill_p1 && !redirect_valid;
    end

    assign imem_addr  = pc_q;
    assign imem_en    = issue;
    assign inst_valid = (count_q != '0);
    assign inst_data  = buf_data[rd_ptr_q];
    assign inst_pc    = buf_pc[rd_ptr_q];
    assign fetch_err  = fetch_err_q;

    // Stage p0: program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= PC_W'(RESET_PC);
        end else if (redirect_valid) begin
            pc_q <= align_pc(redirect_pc);
        end else if (issue) begin
            pc_q <= pc_q + PC_W'(4);
        end
    end

    // Stage p1: memory access in flight, word returns during this stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            kill_p1     <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            vld_p1      <= issue;
            kill_p1     <= redirect_valid && vld_p1;
            fetch_err_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1 <= pc_q;
        end
    end

    // Stage p2: output buffer, head presented to decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (push) begin
            buf_data[wr_ptr_q] <= imem_rdata;
            buf_pc[wr_ptr_q]   <= pc_p1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (redirect_valid) begin
            state_q <= fetch_en ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= fetch_en ? RUN : IDLE;
                RUN:     state_q <= !fetch_en ? IDLE : (credit ? RUN : HOLD);
                HOLD:    state_q <= !fetch_en ? IDLE : (credit ? RUN : HOLD);
                default: state_q <= IDLE;
            endcase
        end
    end

    // The credit rule makes a push into a full buffer without a pop impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == CW'(BUF_DEPTH))));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected (pc, word) pairs are queued as
// fetch stimulus is planned and compared as decode pops them.
module tb_fetch_sequencer;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               fetch_en = 1'b0;
    logic               redirect_valid = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic               inst_valid;
    logic               inst_ready = 1'b0;
    logic [INSTR_W-1:0] inst_data;
    logic [PC_W-1:0]    inst_pc;
    logic               fetch_err;

    int n_checks = 0;
    int n_errs   = 0;
    exp_t exp_q[$];

    logic               s_en, s_valid, s_err;
    logic [PC_W-1:0]    s_addr, s_pc;
    logic [INSTR_W-1:0] s_data;

    fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
        case (a)
            12'h000: return 32'h0050_0613;
            12'h004: return 32'h00B0_6693;
            12'h008: return 32'h00C0_2223;
            default: return 32'hC0DE_0000 | {20'h0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) imem_rdata <= '0;
        else if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [PC_W-1:0] start, input int n);
        logic [PC_W-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + PC_W'(4 * i);
            exp_q.push_back('{pc: a, data: mem_word(a)});
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_en = imem_en; s_addr = imem_addr; s_valid = inst_valid;
        s_err = fetch_err; s_pc = inst_pc; s_data = inst_data;
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("pop_when_empty", 64'(inst_valid & inst_ready), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("inst_pc", 64'(inst_pc), 64'(e.pc));
                check_eq("inst_data", 64'(inst_data), 64'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        fetch_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
        check_eq("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [PC_W-1:0] target, input int n_fetch,
                            input int exp_left, input int exp_err);
        int errs;
        logic vh [1:12];
        logic [PC_W-1:0] base;
        errs = 0;
        base = {target[PC_W-1:2], 2'b00};
        redirect_valid = 1'b1;
        redirect_pc    = target;
        fetch_en       = 1'b1;
        tick();
        check_eq("redir_no_issue", 64'(s_en), 64'd0);
        errs += int'(s_err);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        check_eq("flush_left", 64'(exp_q.size()), 64'(exp_left));
        exp_q.delete();
        push_seq(base, n_fetch);
        for (int k = 1; k <= n_fetch + 5; k++) begin
            if (k == n_fetch + 1) fetch_en = 1'b0;
            tick();
            vh[k] = s_valid;
            errs += int'(s_err);
            if (k <= n_fetch)
                check_eq("redir_issue", {51'd0, s_en, s_addr},
                         {51'd0, 1'b1, base + PC_W'(4 * (k - 1))});
        end
        check_eq("redir_lat1", 64'(vh[1]), 64'd0);
        check_eq("redir_lat2", 64'(vh[2]), 64'd0);
        check_eq("redir_lat3", 64'(vh[3]), 64'd1);
        check_eq("fetch_err_pulses", 64'(errs), 64'(exp_err));
        check_eq("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        // reset state, with fetch_en high to show reset blocks issue
        fetch_en = 1'b1;
        tick();
        check_eq("rst_en", 64'(s_en), 64'd0);
        check_eq("rst_valid", 64'(s_valid), 64'd0);
        check_eq("rst_addr", 64'(s_addr), 64'd0);
        check_eq("rst_pc", 64'(s_pc), 64'd0);
        check_eq("rst_data", 64'(s_data), 64'd0);
        check_eq("rst_err", 64'(s_err), 64'd0);
        do_reset();

        // back-to-back fetch with decode always ready
        fetch_en = 1'b1; inst_ready = 1'b1;
        push_seq(12'h000, 3);
        tick();
        check_eq("t1_c0", {51'd0, s_en, s_addr}, {51'd0, 1'b1, 12'h000});
        check_eq("t1_c0_valid", 64'(s_valid), 64'd0);
        tick();
        check_eq("t1_c1", {51'd0, s_en, s_addr}, {51'd0, 1'b1, 12'h004});
        check_eq("t1_c1_valid", 64'(s_valid), 64'd0);
        tick();
        check_eq("t1_c2", {51'd0, s_en, s_addr}, {51'd0, 1'b1, 12'h008});
        check_eq("t1_c2_valid", 64'(s_valid), 64'd1);
        fetch_en = 1'b0;
        tick();
        check_eq("t1_c3_en", 64'(s_en), 64'd0);
        check_eq("t1_c3_valid", 64'(s_valid), 64'd1);
        drain(4);

        // decode stalls 5 cycles: buffer fills, fetch holds, nothing lost
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b0;
        push_seq(12'h000, 6);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 1) check_eq("t2_c1_en", 64'(s_en), 64'd1);
            if (c >= 2) begin
                check_eq("t2_hold_en", 64'(s_en), 64'd0);
                check_eq("t2_hold_valid", 64'(s_valid), 64'd1);
                check_eq("t2_hold_pc", 64'(s_pc), 64'h000);
                check_eq("t2_hold_data", 64'(s_data), 64'h0050_0613);
            end
        end
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        drain(5);

        // redirect while the fetch of 0x008 is in flight
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        push_seq(12'h000, 2);
        tick();
        tick();
        tick();
        check_eq("t3_c2", {51'd0, s_en, s_addr}, {51'd0, 1'b1, 12'h008});
        redirect(12'h020, 2, 0, 0);

        // redirect near the top of the address space, PC wraps
        redirect(12'hFFC, 3, 0, 0);

        // misaligned redirect target
        redirect(12'h00A, 2, 0, 1);

        // reset mid-stream with the buffer full
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check_eq("t6_full_valid", 64'(inst_valid), 64'd1);
        reset = 1'b1;
        #2;
        check_eq("t6_async_valid", 64'(inst_valid), 64'd0);
        check_eq("t6_async_addr", 64'(imem_addr), 64'd0);
        check_eq("t6_async_en", 64'(imem_en), 64'd0);
        tick();
        tick();
        exp_q.delete();
        reset = 1'b0;
        inst_ready = 1'b1;
        push_seq(12'h000, 3);
        tick();
        check_eq("t6_restart", {51'd0, s_en, s_addr}, {51'd0, 1'b1, 12'h000});
        check_eq("t6_no_stale", 64'(s_valid), 64'd0);
        tick();
        tick();
        drain(5);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
